risc_sequencer: RTL and testbench

- Control sequencer for the VeriRISC core. Runs the fixed 8-phase instruction cycle and decodes the 3-bit opcode into the datapath strobes (address mux select, memory read/write, IR/AC/PC loads, PC increment, data bus enable, halt).
- Sits between the instruction register opcode field / accumulator zero flag and the datapath.
- Adds a sticky halted state and an instruction-retired counter.

---
 rtl/risc_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_risc_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc_sequencer.sv
// -----------------------------------------------------------------------------
// risc_sequencer -- control sequencer for the VeriRISC core.
//
// Steps through the fixed 8-phase instruction cycle and decodes the opcode
// into datapath strobes. A sticky halt flop freezes the machine in phase 4
// after an HLT, and a wrapping counter tracks retired instructions.
//
// Optional feature macro: SINGLE_STEP_EN
//   When defined, the sequencer waits in phase 0 until step_req is high, and
//   step_ack pulses for one cycle after each instruction completes.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   step_req  in   single-step request        (SINGLE_STEP_EN only)
//   step_ack  out  single-step acknowledge    (SINGLE_STEP_EN only)
//   opcode    in   IR opcode field, valid from phase 3 onward
//   zero      in   accumulator-equals-zero flag, used in phase 6
//   phase     out  current phase 0..7
//   sel       out  1: PC drives address bus, 0: IR operand
//   rd, wr    out  memory read enable / write strobe
//   ld_ir, ld_ac, ld_pc, inc_pc, data_e  out  datapath strobes
//   halt      out  processor halted (sticky)
//   retired   out  completed-instruction count
// -----------------------------------------------------------------------------
module risc_sequencer #(
  parameter int OPW  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SINGLE_STEP_EN
  input  logic            step_req,
  output logic            step_ack,
`endif
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  output logic [2:0]      phase,
  output logic            sel,
  output logic            rd,
  output logic            wr,
  output logic            ld_ir,
  output logic            ld_ac,
  output logic            ld_pc,
  output logic            inc_pc,
  output logic            data_e,
  output logic            halt,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  phase_e          phase_q, phase_d;
  logic            halt_q, halt_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic            ack_d;
  logic            step_ok;
  logic            is_hlt, is_skz, is_sto, is_jmp, aluop;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

`ifdef SINGLE_STEP_EN
  logic step_ack_q;
  // Phase 0 is the only stall point; mid-instruction the cycle always completes.
  assign step_ok  = (phase_q != INST_ADDR) || step_req;
  assign step_ack = step_ack_q;
`else
  assign step_ok  = 1'b1;
`endif

  // Next-state logic. HLT in phase 4 sets the flop instead of advancing, so
  // the phase stays frozen at 4 and the halted instruction is never counted.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    phase_d   = phase_q;
    halt_d    = halt_q;
    retired_d = retired_q;
    ack_d     = 1'b0;
    if (!halt_q) begin
      if (phase_q == OP_ADDR && is_hlt) begin
        halt_d = 1'b1;
      end else if (step_ok) begin
        phase_d = phase_e'(phase_q + 3'd1);
        if (phase_q == STORE) begin
          retired_d = retired_q + 1'b1;
          ack_d     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= INST_ADDR;
      halt_q     <= 1'b0;
      retired_q  <= '0;
`ifdef SINGLE_STEP_EN
      step_ack_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      phase_q    <= phase_d;
      halt_q     <= halt_d;
      retired_q  <= retired_d;
`ifdef SINGLE_STEP_EN
      step_ack_q <= ack_d;
`endif
    end
  end

`ifndef SINGLE_STEP_EN
  logic unused_ack;
  assign unused_ack = ack_d;
`endif

  // Strobe decode from the registered phase. Because reset forces phase_q to 0
  // asynchronously, wr and the other strobes drop the moment rst falls.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    if (!halt_q) begin
      unique case (phase_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        OP_ADDR:    inc_pc = 1'b1;
        OP_FETCH:   rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = is_jmp;
          inc_pc = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  // halt rises combinationally in phase 4 with HLT, then the flop holds it.
  assign halt    = halt_q || (phase_q == OP_ADDR && is_hlt);
  assign phase   = phase_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_risc_sequencer -- self-checking bench for risc_sequencer (CNTW=4).
// A phase/halt/retired reference model written from the instruction-cycle
// rules predicts every output each cycle; directed sequences cover reset,
// HLT, JMP, SKZ, STO/LDA and counter wrap, followed by random instructions.
// -----------------------------------------------------------------------------
module tb_risc_sequencer;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      opcode = 3'd0;
  logic            zero = 1'b0;
  logic [2:0]      phase;
  logic            sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [CNTW-1:0] retired;
`ifdef SINGLE_STEP_EN
  logic            step_req = 1'b0;
  logic            step_ack;
  localparam bit   SS = 1'b1;
`else
  localparam bit   SS = 1'b0;
  logic            step_req = 1'b1;
`endif

  risc_sequencer #(.OPW(3), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef SINGLE_STEP_EN
    .step_req(step_req),
    .step_ack(step_ack),
`endif
    .opcode  (opcode),
    .zero    (zero),
    .phase   (phase),
    .sel     (sel),
    .rd      (rd),
    .wr      (wr),
    .ld_ir   (ld_ir),
    .ld_ac   (ld_ac),
    .ld_pc   (ld_pc),
    .inc_pc  (inc_pc),
    .data_e  (data_e),
    .halt    (halt),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers.
  int m_phase;
  bit m_halt;
  int m_retired;
  bit m_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt}, one rule per strobe.
  function automatic logic [8:0] exp_strobes(int ph, int op, bit z, bit halted);
    bit alu, e_sel, e_rd, e_wr, e_ir, e_ac, e_pc, e_inc, e_de, e_h;
    if (halted) return 9'b0_0000_0001;
    alu   = (op >= 2 && op <= 5);
    e_sel = (ph <= 3);
    e_rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    e_wr  = (ph == 7) && (op == 6);
    e_ir  = (ph == 2) || (ph == 3);
    e_ac  = (ph == 7) && alu;
    e_pc  = (ph >= 6) && (op == 7);
    e_inc = (ph == 4) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
    e_de  = (ph >= 6) && (op == 6);
    e_h   = (ph == 4) && (op == 0);
    return {e_sel, e_rd, e_wr, e_ir, e_ac, e_pc, e_inc, e_de, e_h};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_halt = 1'b0; m_retired = 0; m_ack = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_phase"}, phase, m_phase);
    check({tag, "_strobes"}, {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt},
          exp_strobes(m_phase, opcode, zero, m_halt));
    check({tag, "_retired"}, retired, m_retired % (1 << CNTW));
`ifdef SINGLE_STEP_EN
    check({tag, "_ack"}, step_ack, m_ack);
`endif
  endtask

  // One clock: drive inputs, check outputs, clock edge, advance the model.
  // Opcode is randomized in phases 0-2 where it must be ignored.
  task automatic cycle(input int op, input bit z, input string tag);
    if (!m_halt && m_phase < 3) opcode = 3'($urandom);
    else                        opcode = 3'(op);
    zero = z;
    #2;
    check_outputs(tag);
    @(posedge clk);
    m_ack = 1'b0;
    if (!m_halt) begin
      if (m_phase == 4 && opcode == 3'd0) m_halt = 1'b1;
      else if (!(SS && m_phase == 0 && !step_req)) begin
        m_phase = (m_phase + 1) % 8;
        if (m_phase == 0) begin m_retired++; m_ack = 1'b1; end
      end
    end
    #1;
  endtask

  task automatic run_instr(input int op, input bit z, input string tag);
    repeat (8) cycle(op, z, tag);
  endtask

  // Assert reset asynchronously, check, then release on a falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_outputs("por");
    @(negedge clk);
    rst = 1'b1;
`ifdef SINGLE_STEP_EN
    step_req = 1'b1;
`endif

    // Directed opcodes.
    run_instr(7, 1'b0, "jmp");
    run_instr(1, 1'b1, "skz_z1");
    run_instr(1, 1'b0, "skz_z0");
    run_instr(6, 1'b0, "sto");
    run_instr(5, 1'b0, "lda");
    run_instr(2, 1'b1, "add");
    run_instr(3, 1'b0, "and");
    run_instr(4, 1'b1, "xor");

    // Reset mid-phase 5.
    repeat (5) cycle(2, 1'b0, "pre_rst5");
    do_reset("rst_ph5");

    // Reset during STO phase 7: wr must drop immediately.
    repeat (7) cycle(6, 1'b0, "pre_rst7");
    opcode = 3'd6;
    #1;
    check("sto_wr_before_rst", wr, 1'b1);
    do_reset("rst_ph7");

    // HLT straight out of reset.
    repeat (3) cycle(0, 1'b0, "hlt_fetch");
    check("hlt_after3", halt, 1'b0);
    cycle(0, 1'b0, "hlt_ph3");
    opcode = 3'd0;
    #1;
    check("hlt_after4", halt, 1'b1);
    repeat (20) cycle(0, 1'b1, "hlt_frozen");
    check("hlt_phase", phase, 3'd4);
    check("hlt_retired", retired, 0);
    check("hlt_strobes", {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e}, 8'h00);
    do_reset("rst_hlt");

    // JMP then HLT: halt visible after edge 12, one instruction retired.
    run_instr(7, 1'b0, "jmp_then");
    repeat (4) cycle(0, 1'b0, "then_hlt");
    opcode = 3'd0;
    #1;
    check("jmp_hlt_halt", halt, 1'b1);
    check("jmp_hlt_retired", retired, 1);
    repeat (3) cycle(0, 1'b0, "then_hlt_hold");
    do_reset("rst_jmp_hlt");

    // Counter wrap: 17 instructions on a 4-bit counter leaves 1.
    repeat (17) run_instr(2, 1'b0, "wrap");
    check("wrap_retired", retired, 1);

`ifdef SINGLE_STEP_EN
    // Stall in phase 0, then a single one-cycle step.
    do_reset("rst_step");
    step_req = 1'b0;
    repeat (10) cycle(2, 1'b0, "stall");
    check("stall_phase", phase, 3'd0);
    step_req = 1'b1;
    cycle(2, 1'b0, "step_go");
    step_req = 1'b0;
    repeat (7) cycle(2, 1'b0, "step_run");
    check("step_back_phase", phase, 3'd0);
    check("step_ack_pulse", step_ack, 1'b1);
    cycle(2, 1'b0, "step_idle");
    check("step_ack_drop", step_ack, 1'b0);
`endif

    // Random non-HLT instructions with random zero and (if present) step_req.
    for (int n = 0; n < 40 * 8; n++) begin
`ifdef SINGLE_STEP_EN
      step_req = 1'($urandom);
`endif
      cycle($urandom_range(1, 7), 1'($urandom), "rand");
    end

    // Random HLT at the end: must freeze whatever the inputs do.
    while (m_phase != 0) cycle(2, 1'b0, "drain");
`ifdef SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    repeat (12) cycle(0, 1'($urandom), "final_hlt");
    check("final_halt", halt, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
